// File: rtl/cla_seq_adder16.sv
// rtl/cla_seq_adder16.sv - sequential nibble-serial adder/subtractor built on one 4-bit CLA
// Operands are latched at start; one nibble is summed per RUN cycle, LSB first.

module cla4 (
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = X & Y;
    assign p = X ^ Y;
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign S    = p ^ c[3:0];
    assign Cout = c[4];
endmodule

module cla_seq_adder16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic           carry;
    logic [KW-1:0]  k;
    logic [3:0]     nx;
    logic [3:0]     ny;
    logic [3:0]     ns;
    logic           nco;
    logic           last;
    logic           c_into_msb;

    // Select the active nibble of each operand for the shared adder.
    always_comb begin
        nx = 4'b0;
        ny = 4'b0;
        for (int i = 0; i < NIB; i++) begin
            if (k == KW'(i)) begin
                nx = opa[i*4 +: 4];
                ny = opb[i*4 +: 4];
            end
        end
    end

    cla4 u_cla4 (
        .X    (nx),
        .Y    (ny),
        .Cin  (carry),
        .S    (ns),
        .Cout (nco)
    );

    assign last       = (k == KW'(NIB - 1));
    assign c_into_msb = opa[WIDTH-1] ^ opb[WIDTH-1] ^ ns[3];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            carry  <= 1'b0;
            k      <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                opa    <= A;
                opb    <= sub ? ~B : B;
                carry  <= sub;
                k      <= '0;
                result <= '0;
                cout   <= 1'b0;
                ovf    <= 1'b0;
            end else if (state == RUN) begin
                for (int i = 0; i < NIB; i++) begin
                    if (k == KW'(i)) result[i*4 +: 4] <= ns;
                end
                carry <= nco;
                k     <= k + 1'b1;
                if (last) begin
                    cout <= nco;
                    ovf  <= c_into_msb ^ nco;
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_cla_seq_adder16.sv
// tb/tb_cla_seq_adder16.sv - directed self-checking bench for cla_seq_adder16
module tb_cla_seq_adder16;
    localparam int NIB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        busy, done, cout, ovf;
    logic [15:0] result;

    logic        start4 = 1'b0;
    logic        sub4 = 1'b0;
    logic [3:0]  A4 = '0;
    logic [3:0]  B4 = '0;
    logic        busy4, done4, cout4, ovf4;
    logic [3:0]  result4;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    cla_seq_adder16 #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B),
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
    );

    cla_seq_adder16 #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .A(A4), .B(B4),
        .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: modulo-2^16 add or A + ~B + 1, signed overflow from operand/result signs.
    task automatic ref16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [15:0] r, output logic c, output logic o);
        logic [16:0] ext;
        ext = {1'b0, a} + (s ? {1'b0, ~b} : {1'b0, b}) + 17'(s);
        r = ext[15:0];
        c = ext[16];
        if (s) o = (a[15] != b[15]) && (r[15] != a[15]);
        else   o = (a[15] == b[15]) && (r[15] != a[15]);
    endtask

    // Model: cycles remaining until idle; done expected on the last one.
    int          m_cnt = 0;
    logic [15:0] m_res = '0;
    logic        m_cout = 1'b0;
    logic        m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  = 0;
            m_res  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt = m_cnt - 1;
        end else if (start) begin
            m_cnt = NIB + 1;
            ref16(A, B, sub, m_res, m_cout, m_ovf);
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_cnt != 0));
        chk("done", 32'(done), 32'(m_cnt == 1));
        if (m_cnt == 0 || m_cnt == 1) begin
            chk("result", 32'(result), 32'(m_res));
            chk("cout", 32'(cout), 32'(m_cout));
            chk("ovf", 32'(ovf), 32'(m_ovf));
        end
    end

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [15:0] er, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        A = a; B = b; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(NIB));
        chk("lit_result", 32'(result), 32'(er));
        chk("lit_cout", 32'(cout), 32'(ec));
        chk("lit_ovf", 32'(ovf), 32'(eo));
        @(negedge clk);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input logic [3:0] er, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        A4 = a; B4 = b; sub4 = s; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("w4_latency", 32'(lat), 32'd1);
        chk("w4_result", 32'(result4), 32'(er));
        chk("w4_cout", 32'(cout4), 32'(ec));
        chk("w4_ovf", 32'(ovf4), 32'(eo));
        @(negedge clk);
        chk("w4_idle", 32'(busy4), 32'd0);
    endtask

    initial begin
        int gap;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst4_busy", 32'(busy4), 32'd0);

        // Start on the first edge after reset release must be accepted.
        rst_n = 1'b1;
        run16(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        run16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run16(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run16(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run16(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);
        run16(16'hA5A5, 16'h5A5B, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Start held high: acceptance every NIB+2 cycles.
        @(negedge clk);
        A = 16'h0100; B = 16'h0023; sub = 1'b0; start = 1'b1;
        gap = 0;
        while (!done && gap < 20) begin @(negedge clk); gap++; end
        chk("b2b_first_result", 32'(result), 32'h0123);
        gap = 0;
        @(negedge clk);
        gap++;
        while (!done && gap < 20) begin @(negedge clk); gap++; end
        chk("b2b_interval", 32'(gap), 32'(NIB + 2));
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Start pulse and operand change while busy must be ignored.
        @(negedge clk);
        A = 16'h0F0F; B = 16'h0101; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 16'hFFFF; B = 16'hFFFF; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        gap = 0;
        while (!done && gap < 20) begin @(negedge clk); gap++; end
        chk("ignored_start_result", 32'(result), 32'h1010);
        @(negedge clk);
        chk("ignored_start_idle", 32'(busy), 32'd0);

        // Mid-run reset: immediate clear, no done pulse.
        @(negedge clk);
        A = 16'hFFFF; B = 16'hFFFF; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        repeat (3) @(negedge clk);
        chk("midrst_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        run16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

        run4(4'hF, 4'hF, 1'b0, 4'hE, 1'b1, 1'b0);
        run4(4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0);
        run4(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
